// File: rtl/gameplay_judge.sv
// rtl/gameplay_judge.sv - note-judging engine: strum vs chord, hit/miss pulses, streak/multiplier/score
module gameplay_judge #(
  parameter int LANES         = 5,
  parameter int STREAK_W      = 8,
  parameter int SCORE_W       = 20,
  parameter int NOTE_POINTS   = 50,
  parameter int MULT_STEP     = 10,
  parameter int MULT_MAX      = 4,
  parameter bit GHOST_PENALTY = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pause,
  input  logic                stop,
  input  logic [LANES-1:0]    buttons,
  input  logic                strum,
  input  logic [LANES-1:0]    notes_to_play,
  output logic [LANES-1:0]    LEDR,
  output logic                note_hit,
  output logic                note_miss,
  output logic [LANES-1:0]    miss_mask,
  output logic [STREAK_W-1:0] streak,
  output logic [STREAK_W-1:0] best_streak,
  output logic [2:0]          multiplier,
  output logic [SCORE_W-1:0]  score
);

  localparam int SUM_W = SCORE_W + 12;

  typedef enum logic [1:0] {IDLE, ARMED, JUDGE, HOLDOFF} state_t;

  state_t               state_q, state_d;
  logic                 strum_q, strum_d;
  logic [LANES-1:0]     chord_q, chord_d;
  logic [LANES-1:0]     snap_q, snap_d;
  logic                 force_miss_q, force_miss_d;
  logic                 hit_q, hit_d;
  logic                 miss_q, miss_d;
  logic [LANES-1:0]     mask_q, mask_d;
  logic [STREAK_W-1:0]  streak_q, streak_d;
  logic [STREAK_W-1:0]  best_q, best_d;
  logic [2:0]           mult_q, mult_d;
  logic [SCORE_W-1:0]   score_q, score_d;

  logic                 strum_rise;
  logic                 notes_none;
  logic [STREAK_W-1:0]  streak_inc;
  logic [STREAK_W-1:0]  mult_steps;
  logic [2:0]           mult_inc;
  logic [SUM_W-1:0]     score_sum;

  assign strum_rise = strum & ~strum_q;
  assign notes_none = (notes_to_play == '0);

  // Hit-path arithmetic, evaluated from the current counters every cycle.
  always_comb begin
    streak_inc = (&streak_q) ? streak_q : streak_q + 1'b1;
    mult_steps = streak_inc / STREAK_W'(MULT_STEP);
    mult_inc   = (mult_steps >= STREAK_W'(MULT_MAX - 1)) ? 3'(MULT_MAX)
                                                          : 3'(mult_steps) + 3'd1;
    score_sum  = SUM_W'(score_q) + SUM_W'(NOTE_POINTS) * SUM_W'(mult_inc);
  end

  always_comb begin
    state_d      = state_q;
    strum_d      = strum;
    chord_d      = chord_q;
    snap_d       = snap_q;
    force_miss_d = force_miss_q;
    hit_d        = hit_q;
    miss_d       = miss_q;
    mask_d       = mask_q;
    streak_d     = streak_q;
    best_d       = best_q;
    mult_d       = mult_q;
    score_d      = score_q;
    if (!pause) begin
      hit_d  = 1'b0;
      miss_d = 1'b0;
      mask_d = '0;
      unique case (state_q)
        IDLE: begin
          if (!notes_none) begin
            state_d      = ARMED;
            chord_d      = notes_to_play;
            force_miss_d = 1'b0;
          end else if (strum_rise && GHOST_PENALTY) begin
            state_d      = JUDGE;
            chord_d      = '0;
            snap_d       = buttons;
            force_miss_d = 1'b1;
          end
        end
        ARMED: begin
          if (strum_rise) begin
            state_d = JUDGE;
            snap_d  = buttons;
          end else if (notes_none) begin
            // Passed note: empty snapshot makes the mask equal to the chord.
            state_d = JUDGE;
            snap_d  = '0;
          end
        end
        JUDGE: begin
          state_d = HOLDOFF;
          if (!force_miss_q && (snap_q == chord_q)) begin
            hit_d    = 1'b1;
            streak_d = streak_inc;
            best_d   = (streak_inc > best_q) ? streak_inc : best_q;
            mult_d   = mult_inc;
            score_d  = (score_sum > SUM_W'({SCORE_W{1'b1}})) ? {SCORE_W{1'b1}}
                                                             : score_sum[SCORE_W-1:0];
          end else begin
            miss_d   = 1'b1;
            mask_d   = chord_q ^ snap_q;
            streak_d = '0;
            mult_d   = 3'd1;
          end
        end
        HOLDOFF: begin
          if (notes_none && !strum) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset || stop) begin
      state_q      <= IDLE;
      strum_q      <= 1'b0;
      chord_q      <= '0;
      snap_q       <= '0;
      force_miss_q <= 1'b0;
      hit_q        <= 1'b0;
      miss_q       <= 1'b0;
      mask_q       <= '0;
      streak_q     <= '0;
      best_q       <= '0;
      mult_q       <= 3'd1;
      score_q      <= '0;
    end else begin
      state_q      <= state_d;
      strum_q      <= strum_d;
      chord_q      <= chord_d;
      snap_q       <= snap_d;
      force_miss_q <= force_miss_d;
      hit_q        <= hit_d;
      miss_q       <= miss_d;
      mask_q       <= mask_d;
      streak_q     <= streak_d;
      best_q       <= best_d;
      mult_q       <= mult_d;
      score_q      <= score_d;
    end
  end

  // Pending pulses are held through pause and surface once it drops.
  assign LEDR        = notes_to_play;
  assign note_hit    = hit_q & ~pause;
  assign note_miss   = miss_q & ~pause;
  assign miss_mask   = pause ? '0 : mask_q;
  assign streak      = streak_q;
  assign best_streak = best_q;
  assign multiplier  = mult_q;
  assign score       = score_q;

endmodule

// File: tb/tb_gameplay_judge.sv
// tb/tb_gameplay_judge.sv - directed self-checking bench for gameplay_judge
module tb_gameplay_judge;

  logic       clk = 1'b0;
  logic       reset, pause, stop, strum;
  logic [4:0] buttons, notes_to_play;
  logic [4:0] ledr, miss_mask, ledr_ng, miss_mask_ng;
  logic       note_hit, note_miss, note_hit_ng, note_miss_ng;
  logic [7:0] streak, best_streak, streak_ng, best_streak_ng;
  logic [2:0] multiplier, multiplier_ng;
  logic [19:0] score, score_ng;

  int checks = 0;
  int failures = 0;

  logic       o_early, o_hit, o_miss, o_late;
  logic [4:0] o_mask;

  always #5 clk = ~clk;

  gameplay_judge dut (
    .clk(clk), .reset(reset), .pause(pause), .stop(stop), .buttons(buttons),
    .strum(strum), .notes_to_play(notes_to_play), .LEDR(ledr),
    .note_hit(note_hit), .note_miss(note_miss), .miss_mask(miss_mask),
    .streak(streak), .best_streak(best_streak), .multiplier(multiplier), .score(score)
  );

  gameplay_judge #(.GHOST_PENALTY(1'b0)) dut_ng (
    .clk(clk), .reset(reset), .pause(pause), .stop(stop), .buttons(buttons),
    .strum(strum), .notes_to_play(notes_to_play), .LEDR(ledr_ng),
    .note_hit(note_hit_ng), .note_miss(note_miss_ng), .miss_mask(miss_mask_ng),
    .streak(streak_ng), .best_streak(best_streak_ng), .multiplier(multiplier_ng),
    .score(score_ng)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a chord, strum with btns; observe the pulse one cycle early, on time and one late.
  task automatic play_note(input logic [4:0] chord, input logic [4:0] btns);
    notes_to_play = chord; buttons = 5'b0; strum = 1'b0;
    step();
    buttons = btns; strum = 1'b1;
    step();
    o_early = note_hit | note_miss;
    step();
    o_hit = note_hit; o_miss = note_miss; o_mask = miss_mask;
    strum = 1'b0; notes_to_play = 5'b0;
    step();
    o_late = note_hit | note_miss;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    pause = 1'b0; stop = 1'b0; strum = 1'b0; buttons = 5'b0;
    notes_to_play = 5'b01010;
    do_reset();
    checks++;
    if ({note_hit, note_miss} !== 2'b00) begin
      failures++; $display("FAIL reset_pulses got=%b want=00", {note_hit, note_miss});
    end
    checks++;
    if (streak !== 8'd0 || score !== 20'd0 || best_streak !== 8'd0) begin
      failures++; $display("FAIL reset_counters streak=%0d best=%0d score=%0d want 0", streak, best_streak, score);
    end
    checks++;
    if (multiplier !== 3'd1) begin
      failures++; $display("FAIL reset_mult got=%0d want=1", multiplier);
    end
    checks++;
    if (ledr !== 5'b01010) begin
      failures++; $display("FAIL reset_ledr got=%b want=01010", ledr);
    end
    notes_to_play = 5'b0;
    step();
  endtask

  task automatic test_single_hit();
    play_note(5'b00101, 5'b00101);
    checks++;
    if ({o_early, o_hit, o_miss, o_late} !== 4'b0100) begin
      failures++; $display("FAIL hit_timing got=%b want=0100", {o_early, o_hit, o_miss, o_late});
    end
    checks++;
    if (streak !== 8'd1 || score !== 20'd50) begin
      failures++; $display("FAIL hit_counters streak=%0d score=%0d want 1/50", streak, score);
    end
  endtask

  task automatic test_multiplier();
    repeat (9) play_note(5'b00101, 5'b00101);
    checks++;
    if (streak !== 8'd10 || multiplier !== 3'd2 || score !== 20'd550) begin
      failures++; $display("FAIL mult10 streak=%0d mult=%0d score=%0d want 10/2/550", streak, multiplier, score);
    end
    repeat (30) play_note(5'b11000, 5'b11000);
    checks++;
    if (streak !== 8'd40 || multiplier !== 3'd4 || score !== 20'd5150) begin
      failures++; $display("FAIL mult40 streak=%0d mult=%0d score=%0d want 40/4/5150", streak, multiplier, score);
    end
  endtask

  task automatic test_wrong_chord();
    play_note(5'b00101, 5'b00100);
    checks++;
    if ({o_early, o_hit, o_miss, o_late} !== 4'b0010 || o_mask !== 5'b00001) begin
      failures++; $display("FAIL wrong_chord pulses=%b mask=%b want 0010/00001", {o_early, o_hit, o_miss, o_late}, o_mask);
    end
    checks++;
    if (streak !== 8'd0 || best_streak !== 8'd40 || score !== 20'd5150 || multiplier !== 3'd1) begin
      failures++; $display("FAIL wrong_chord_counters streak=%0d best=%0d score=%0d mult=%0d want 0/40/5150/1", streak, best_streak, score, multiplier);
    end
    play_note(5'b00011, 5'b00111);
    checks++;
    if (o_miss !== 1'b1 || o_mask !== 5'b00100) begin
      failures++; $display("FAIL extra_lane miss=%b mask=%b want 1/00100", o_miss, o_mask);
    end
  endtask

  task automatic test_passed_and_ghost();
    notes_to_play = 5'b10000; buttons = 5'b0; strum = 1'b0;
    step();
    notes_to_play = 5'b0;
    step();
    step();
    checks++;
    if (note_miss !== 1'b1 || note_hit !== 1'b0 || miss_mask !== 5'b10000) begin
      failures++; $display("FAIL passed_note miss=%b hit=%b mask=%b want 1/0/10000", note_miss, note_hit, miss_mask);
    end
    step();
    buttons = 5'b00011; strum = 1'b1;
    step();
    step();
    checks++;
    if (note_miss !== 1'b1 || miss_mask !== 5'b00011) begin
      failures++; $display("FAIL ghost_penalty miss=%b mask=%b want 1/00011", note_miss, miss_mask);
    end
    checks++;
    if (note_miss_ng !== 1'b0 || note_hit_ng !== 1'b0) begin
      failures++; $display("FAIL ghost_ignored miss=%b hit=%b want 0/0", note_miss_ng, note_hit_ng);
    end
    strum = 1'b0; buttons = 5'b0;
    step();
  endtask

  task automatic test_pause_stop();
    logic seen;
    do_reset();
    play_note(5'b00001, 5'b00001);
    notes_to_play = 5'b00101; buttons = 5'b0; strum = 1'b0;
    step();
    pause = 1'b1; strum = 1'b1; buttons = 5'b00101;
    step();
    strum = 1'b0;
    step();
    pause = 1'b0;
    seen = 1'b0;
    repeat (3) begin
      step();
      seen = seen | note_hit | note_miss;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++; $display("FAIL pause_strum pulse=%b want 0", seen);
    end
    strum = 1'b1;
    step();
    step();
    checks++;
    if (note_hit !== 1'b1 || streak !== 8'd2) begin
      failures++; $display("FAIL after_pause_hit hit=%b streak=%0d want 1/2", note_hit, streak);
    end
    stop = 1'b1; strum = 1'b0;
    step();
    checks++;
    if (streak !== 8'd0 || best_streak !== 8'd0 || score !== 20'd0 || multiplier !== 3'd1 || note_hit !== 1'b0) begin
      failures++; $display("FAIL stop_clear streak=%0d best=%0d score=%0d mult=%0d hit=%b", streak, best_streak, score, multiplier, note_hit);
    end
    stop = 1'b0;
    step();
    strum = 1'b1; buttons = 5'b00101;
    step();
    step();
    checks++;
    if (note_hit !== 1'b1) begin
      failures++; $display("FAIL stop_to_idle hit=%b want 1", note_hit);
    end
    strum = 1'b0; notes_to_play = 5'b0;
    step();
  endtask

  task automatic test_back_to_back_saturation();
    do_reset();
    repeat (256) play_note(5'b00001, 5'b00001);
    checks++;
    if (streak !== 8'd255 || best_streak !== 8'd255) begin
      failures++; $display("FAIL streak_sat streak=%0d best=%0d want 255/255", streak, best_streak);
    end
    checks++;
    if (multiplier !== 3'd4 || score !== 20'd48350) begin
      failures++; $display("FAIL sat_score mult=%0d score=%0d want 4/48350", multiplier, score);
    end
  endtask

  initial begin
    test_reset();
    test_single_hit();
    test_multiplier();
    test_wrong_chord();
    test_passed_and_ghost();
    test_pause_stop();
    test_back_to_back_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
